reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width.
REQ-003 The block SHALL have parameter DEPTH, default 32, number of registers (2 <= DEPTH <= 2**ADDR_W).
REQ-004 The block SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-005 The block SHALL have parameter SP_IDX, default 29, index of the register with non-zero reset value.
REQ-006 The block SHALL have parameter SP_INIT, default 252, reset value of register SP_IDX.
REQ-007 The block SHALL have port elk  input  1  clock; all state changes on its rising edge.
REQ-008 The block SHALL have port nrst  input  1  reset, asynchronous, active-high.
REQ-009 The block SHALL have port wr_en  input  1  write request.
REQ-010 The block SHALL have port wr_addr  input  ADDR_W  write address.
REQ-011 The block SHALL have port wr_data  input  DATA_W  write data.
REQ-012 The block SHALL have port rd_addr  input  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-013 The block SHALL have port rd_data  output  NRD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-014 The block SHALL have port clr_req  input  1  request a sequential clear sweep.
REQ-015 The block SHALL have port busy  output  1  sweep in progress.
REQ-016 The block SHALL have port clr_done  output  1  one-cycle pulse at sweep completion.
REQ-017 The block SHALL have port wr_err  output  1  one-cycle pulse for a rejected write.

Function
REQ-018 Register 0 SHALL be hard-wired to zero: it is never written and always reads 0.
REQ-019 Reads SHALL have 1-cycle latency: rd_data[i] after edge n reflects rd_addr[i] sampled at edge n.
REQ-020 Read bypass: if an accepted write at edge n targets the same address as rd_addr[i], rd_data[i] after edge n SHALL be wr_data (write-first).
REQ-021 All NRD ports SHALL read independently, including the same address on several ports in one cycle.
REQ-022 A read of an address >= DEPTH SHALL return 0.
REQ-023 A write SHALL be accepted at an edge when wr_en=1, wr_addr!=0, wr_addr<DEPTH and state is IDLE; the register updates at that edge.
REQ-024 A write to address 0, to an address >= DEPTH, or during SWEEP SHALL be dropped, with wr_err=1 for exactly the following cycle.
REQ-025 FSM states SHALL be IDLE and SWEEP; in IDLE, clr_req=1 at an edge -> SWEEP, busy=1, sweep index k=1.
REQ-026 In SWEEP, each edge SHALL restore register k to its reset value (SP_INIT if k=SP_IDX, else 0) and increment k.
REQ-027 The edge that restores k=DEPTH-1 SHALL return the FSM to IDLE, drop busy, and raise clr_done for one cycle; a sweep therefore takes DEPTH-1 cycles.
REQ-028 clr_req during SWEEP SHALL be ignored; clr_req with wr_en in IDLE at the same edge: the write SHALL be accepted and the sweep starts.
REQ-029 Reads during SWEEP SHALL return current contents (restored registers read their reset value); bypass SHALL also cover the register restored at that edge.

Reset
REQ-030 While nrst=1, all registers SHALL take reset values (SP_IDX=SP_INIT, others 0), FSM=IDLE, k=1, rd_data=0, busy=0, clr_done=0, wr_err=0.
REQ-031 nrst asserted mid-sweep SHALL abort the sweep immediately; operation resumes in IDLE on the first edge after release.

Verification
REQ-032 The bench SHALL check: reset release, read ports 0/1 at addr 29/5 -> rd_data 252 / 0 one cycle later.
REQ-033 The bench SHALL check: write 0xDEADBEEF to addr 7 while port 0 reads addr 7 at the same edge -> rd_data[0]=0xDEADBEEF after that edge.
REQ-034 The bench SHALL check: write 0x11111110 to addr 0 -> wr_err pulse 1 cycle, later read addr 0 = 0.
REQ-035 The bench SHALL check: fill regs 1..31 with index value, pulse clr_req -> busy high 31 cycles, clr_done pulse, all read 0 except r29=252; a write issued at cycle 10 of the sweep is dropped with wr_err.
REQ-036 The bench SHALL check: nrst asserted at sweep cycle 12 -> busy=0 immediately, all registers at reset values, new write accepted after release.
REQ-037 The bench SHALL check: DEPTH=16, NRD=3, read addr 20 -> 0; write to addr 20 -> wr_err.

Source files
------------

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write-first bypass and sequential clear sweep
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int NRD     = 2,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 252
) (
    input  logic                     elk,
    input  logic                     nrst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     wr_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // DEPTH may equal 2**ADDR_W, so the bound needs one extra bit
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] K_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(DEPTH - 1);

    function automatic logic [DATA_W-1:0] reset_val(input int idx);
        return (idx == SP_IDX) ? DATA_W'(SP_INIT) : '0;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic                restore;
    logic                done_d;
    logic                write_ok;
    logic                err_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];
    logic [NRD*DATA_W-1:0] rd_next;

    assign busy = (state_q == SWEEP);

    // Sweep sequencing and write acceptance
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        restore  = 1'b0;
        done_d   = 1'b0;
        write_ok = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < DEPTH_V) && (state_q == IDLE);
        err_d    = wr_en && !write_ok;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    k_d     = K_FIRST;
                end
            end
            SWEEP: begin
                restore = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = IDLE;
                    k_d     = K_FIRST;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_q + K_FIRST;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = K_FIRST;
            end
        endcase
    end

    // Next register contents; reads use this so writes and restores bypass to the ports
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (write_ok && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
            end
            if (restore && (k_q == ADDR_W'(i))) begin
                regs_d[i] = reset_val(i);
            end
        end
    end

    // Read muxes; an address with no matching register yields zero
    always_comb begin
        rd_next = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    rd_next[p*DATA_W +: DATA_W] = regs_d[i];
                end
            end
        end
    end

    // Register storage
    always_ff @(posedge elk or posedge nrst) begin
        if (nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= reset_val(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // FSM state, sweep index and registered outputs
    always_ff @(posedge elk or posedge nrst) begin
        if (nrst) begin
            state_q  <= IDLE;
            k_q      <= K_FIRST;
            rd_data  <= '0;
            clr_done <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            rd_data  <= rd_next;
            clr_done <= done_d;
            wr_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp
module tb_reg_file_mp;

    logic        elk = 1'b0;
    logic        nrst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic        wr_err;

    logic        w16_en;
    logic [4:0]  w16_addr;
    logic [31:0] w16_data;
    logic [14:0] rd16_addr;
    logic [95:0] rd16_data;
    logic        clr16;
    logic        busy16;
    logic        done16;
    logic        err16;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 elk = ~elk;

    reg_file_mp dut (
        .elk(elk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req), .busy(busy),
        .clr_done(clr_done), .wr_err(wr_err)
    );

    reg_file_mp #(.DEPTH(16), .NRD(3)) dut16 (
        .elk(elk), .nrst(nrst), .wr_en(w16_en), .wr_addr(w16_addr), .wr_data(w16_data),
        .rd_addr(rd16_addr), .rd_data(rd16_data), .clr_req(clr16), .busy(busy16),
        .clr_done(done16), .wr_err(err16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the default-parameter instance
    logic [31:0] m_mem [32];
    int          m_k;
    logic [31:0] m_rd [2];
    logic        m_err;
    logic        m_done;
    bit          m_ok;

    always @(posedge elk or posedge nrst) begin
        if (nrst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = (i == 29) ? 32'd252 : 32'd0;
            m_k    = 0;
            m_rd[0] = 0;
            m_rd[1] = 0;
            m_err  = 0;
            m_done = 0;
        end else begin
            m_ok   = wr_en && (wr_addr != 0) && (m_k == 0);
            m_err  = wr_en && !m_ok;
            m_done = 0;
            if (m_ok) m_mem[wr_addr] = wr_data;
            if (m_k != 0) begin
                m_mem[m_k] = (m_k == 29) ? 32'd252 : 32'd0;
                if (m_k == 31) begin
                    m_k    = 0;
                    m_done = 1;
                end else begin
                    m_k++;
                end
            end else if (clr_req) begin
                m_k = 1;
            end
            for (int p = 0; p < 2; p++) m_rd[p] = m_mem[rd_addr[p*5 +: 5]];
        end
    end

    // Every-cycle comparison against the model
    always @(negedge elk) begin
        if (chk_en) begin
            check("m_rd0", rd_data[31:0], m_rd[0]);
            check("m_rd1", rd_data[63:32], m_rd[1]);
            check("m_busy", {31'd0, busy}, {31'd0, (m_k != 0)});
            check("m_done", {31'd0, clr_done}, {31'd0, m_done});
            check("m_err", {31'd0, wr_err}, {31'd0, m_err});
        end
    end

    int n;

    initial begin
        nrst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; clr_req = 0;
        w16_en = 0; w16_addr = 0; w16_data = 0; rd16_addr = 0; clr16 = 0;
        repeat (3) @(negedge elk);
        check("rst_rd", rd_data[31:0], 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err", {31'd0, wr_err}, 0);
        chk_en = 1;
        nrst = 0;

        rd_addr = {5'd5, 5'd29};
        @(negedge elk);
        check("sp_read", rd_data[31:0], 252);
        check("r5_read", rd_data[63:32], 0);

        wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd7};
        @(negedge elk);
        wr_en = 0;
        check("bypass", rd_data[31:0], 32'hDEADBEEF);
        check("bypass_err", {31'd0, wr_err}, 0);

        wr_en = 1; wr_addr = 0; wr_data = 32'h11111110; rd_addr = {5'd0, 5'd0};
        @(negedge elk);
        wr_en = 0;
        check("wr0_err", {31'd0, wr_err}, 1);
        check("wr0_rd", rd_data[31:0], 0);
        @(negedge elk);
        check("wr0_err_pulse", {31'd0, wr_err}, 0);
        check("wr0_rd_later", rd_data[31:0], 0);

        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = i;
            @(negedge elk);
        end
        wr_en = 0;
        rd_addr = {5'd31, 5'd12};
        @(negedge elk);
        check("fill_r12", rd_data[31:0], 12);
        check("fill_r31", rd_data[63:32], 31);

        clr_req = 1;
        @(negedge elk);
        clr_req = 0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 10) begin
                wr_en = 1; wr_addr = 5'd20; wr_data = 32'h5555;
            end else begin
                wr_en = 0;
            end
            if (n == 11) check("sweep_wr_err", {31'd0, wr_err}, 1);
            @(negedge elk);
        end
        wr_en = 0;
        check("sweep_len", n, 31);
        check("sweep_done", {31'd0, clr_done}, 1);
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            @(negedge elk);
            check("swept_lo", rd_data[31:0], (a == 29) ? 32'd252 : 32'd0);
            check("swept_hi", rd_data[63:32], (a + 1 == 29) ? 32'd252 : 32'd0);
        end

        wr_en = 1; wr_addr = 5; wr_data = 32'h55;
        @(negedge elk);
        wr_en = 0; clr_req = 1;
        @(negedge elk);
        clr_req = 0;
        repeat (11) @(negedge elk);
        check("abort_pre_busy", {31'd0, busy}, 1);
        #2 nrst = 1;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_rd", rd_data[31:0], 0);
        @(negedge elk);
        #2 nrst = 0;
        @(negedge elk);
        wr_en = 1; wr_addr = 9; wr_data = 32'h99; rd_addr = {5'd5, 5'd9};
        @(negedge elk);
        wr_en = 0;
        check("post_rst_wr", rd_data[31:0], 32'h99);
        check("post_rst_r5", rd_data[63:32], 0);
        rd_addr = {5'd29, 5'd9};
        @(negedge elk);
        check("post_rst_r9", rd_data[31:0], 32'h99);
        check("post_rst_sp", rd_data[63:32], 252);

        w16_en = 1; w16_addr = 20; w16_data = 32'hAAAA; rd16_addr = {5'd15, 5'd20, 5'd20};
        @(negedge elk);
        w16_en = 0;
        check("d16_err", {31'd0, err16}, 1);
        check("d16_rd20", rd16_data[31:0], 0);
        w16_en = 1; w16_addr = 15; w16_data = 32'h1234; rd16_addr = {5'd15, 5'd15, 5'd15};
        @(negedge elk);
        w16_en = 0;
        check("d16_noerr", {31'd0, err16}, 0);
        check("d16_p0", rd16_data[31:0], 32'h1234);
        check("d16_p1", rd16_data[63:32], 32'h1234);
        check("d16_p2", rd16_data[95:64], 32'h1234);
        rd16_addr = {5'd29, 5'd16, 5'd15};
        @(negedge elk);
        check("d16_r15", rd16_data[31:0], 32'h1234);
        check("d16_r16", rd16_data[63:32], 0);
        check("d16_r29", rd16_data[95:64], 0);
        clr16 = 1;
        @(negedge elk);
        clr16 = 0;
        n = 0;
        while (busy16 && n < 100) begin
            n++;
            @(negedge elk);
        end
        check("d16_sweep_len", n, 15);
        check("d16_done", {31'd0, done16}, 1);

        for (int c = 0; c < 800; c++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rd_addr = 10'($urandom);
            clr_req = ($urandom_range(0, 39) == 0);
            @(negedge elk);
        end
        wr_en = 0; clr_req = 0;
        @(negedge elk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
